decoder_scan_ctrl: RTL and testbench
====================================

Name: decoder_scan_ctrl

Overview:
Sequential select generator that sits directly upstream of the 3x8 decoder. It drives the decoder's 3-bit select inputs, stepping through the channels enabled in a mask and holding each one for a programmable number of cycles. It runs either a single pass or continuously. It also produces an enable qualifier and status pulses for downstream logic.

Parameters:
DWELL_W, 4, width of the per-channel dwell count; dwell range is 1..2^DWELL_W-1 cycles.

Ports:
clk_in  input  1  clock; all state updates on the rising edge
rst_n_in  input  1  reset, synchronous, active-low
start_in  input  1  start a scan; sampled in IDLE only
stop_in  input  1  abort the scan; sampled in SCAN only
cont_in  input  1  1 = continuous scan, 0 = single pass; latched at start
mask_in  input  8  channel enable mask, bit k = channel k; latched at start
dwell_in  input  DWELL_W  cycles per channel; latched at start; 0 is treated as 1
sel_out  output  3  select code to decoder; sel_out[2] drives i1_in, sel_out[1] drives i2_in, sel_out[0] drives i3_in
en_out  output  1  1 while sel_out is a valid scanned channel
busy_out  output  1  1 while in SCAN
wrap_out  output  1  1-cycle pulse when the scan returns from the last enabled channel to the first in continuous mode
done_out  output  1  1-cycle pulse when a single pass completes normally
err_out  output  1  1-cycle pulse when start_in is seen with mask_in == 0

Behaviour:
- Reset (rst_n_in=0 at a clock edge):
  - state=IDLE; sel_out=0; en_out=0; busy_out=0; all pulses=0.
  - Internal mask, dwell, cont and counter registers are cleared.
  - Reset mid-scan aborts immediately; no done_out or wrap_out is issued.
- All outputs are registered. Pulses are high for exactly one cycle.
- States: IDLE, SCAN.
- IDLE: sel_out=0, en_out=0, busy_out=0.
  - start_in=1 with mask_in!=0:
    - Latch mask, cont and dwell_eff = max(dwell_in,1).
    - Next cycle: sel_out = lowest set bit index of mask, en_out=1, busy_out=1, cnt = dwell_eff-1, state=SCAN.
  - start_in=1 with mask_in==0: stay in IDLE; err_out=1 the next cycle.
- SCAN: en_out=1, busy_out=1.
  - start_in is ignored. Changes on mask_in, dwell_in and cont_in have no effect until the next start.
  - Each channel is presented for exactly dwell_eff consecutive cycles.
  - Per cycle, in priority order:
    1. stop_in=1: next cycle state=IDLE, sel_out=0, en_out=0, busy_out=0. No done_out or wrap_out, even if the dwell ends on that same cycle.
    2. cnt!=0: cnt decrements; sel_out holds.
    3. cnt==0: search for the next enabled channel with index > sel_out (no wrap during the search).
       - Found: sel_out = that index; cnt reloads to dwell_eff-1.
       - Not found, cont=1: sel_out = lowest enabled index; cnt reloads; wrap_out=1 for one cycle, aligned with the new sel_out. Single-bit mask re-selects the same channel.
       - Not found, cont=0: state=IDLE; sel_out=0; en_out=0; busy_out=0; done_out=1 for one cycle.
- A new start may be accepted on the cycle after return to IDLE, which is the same cycle done_out is high.
- sel_out is always valid to the decoder. When en_out=0, sel_out is 0.

Test Plan:
1. Reset, single pass, full mask:
   - Stimulus: rst_n_in low 2 cycles, then mask=8'hFF, dwell=1, cont=0, start 1 cycle.
   - Required: sel_out = 0,1,...,7 on consecutive cycles with en_out=1. The cycle after sel=7: en_out=0, sel_out=0, done_out=1 for 1 cycle.
   - Also check the decoder one-hot output walks o1..o8.
2. Sparse mask with dwell:
   - Stimulus: mask=8'b1010_0100, dwell=3, cont=0.
   - Required: sel_out=2 for 3 cycles, then 5 for 3, then 7 for 3, then done_out.
   - mask_in changed mid-scan has no effect.
3. Continuous wrap:
   - Stimulus: mask=8'b1000_0001, dwell=2, cont=1.
   - Required: sel pattern 0,0,7,7,0,0,... with wrap_out=1 on the first cycle of each return to 0. done_out never asserts.
   - Then stop_in 1 cycle: next cycle en_out=0, busy_out=0, no pulses.
4. Edge cases on start:
   - mask=0 with start: err_out=1 for 1 cycle, busy_out stays 0.
   - dwell=0 with mask=8'h03: behaves as dwell=1 (sel 0,1, done_out).
   - start_in during SCAN is ignored.
5. Reset mid-scan and same-cycle events:
   - rst_n_in low during the sel=4 dwell: next cycle all outputs are at reset values, and a subsequent start behaves as in scenario 1.
   - stop_in asserted on the final cycle of the last channel with cont=0: done_out stays 0.

Source files
------------

// File: rtl/decoder_scan_ctrl_if.sv
// Command/status bundle between a scan requester and decoder_scan_ctrl.
// The requester side drives start/stop/config; the controller returns select and status.
interface decoder_scan_ctrl_if #(
    parameter int DWELL_W = 4
);
    logic               start_in;
    logic               stop_in;
    logic               cont_in;
    logic [7:0]         mask_in;
    logic [DWELL_W-1:0] dwell_in;
    logic [2:0]         sel_out;
    logic               en_out;
    logic               busy_out;
    logic               wrap_out;
    logic               done_out;
    logic               err_out;

    modport master (
        output start_in, stop_in, cont_in, mask_in, dwell_in,
        input  sel_out, en_out, busy_out, wrap_out, done_out, err_out
    );

    modport slave (
        input  start_in, stop_in, cont_in, mask_in, dwell_in,
        output sel_out, en_out, busy_out, wrap_out, done_out, err_out
    );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Steps a 3x8 decoder select through the channels enabled in a mask, holding
// each for a programmable dwell; single pass or continuous, with status pulses.
module decoder_scan_ctrl #(
    parameter int DWELL_W = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    decoder_scan_ctrl_if.slave   bus
);
    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               wrap_q, wrap_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [7:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               cont_q, cont_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    logic [DWELL_W-1:0] dwell_eff;
    logic [2:0]         start_idx;
    logic [2:0]         first_idx;
    logic [2:0]         next_idx;
    logic               next_found;

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) idx = 3'(i);
        return idx;
    endfunction

    // Search upward only; wrap-around is handled separately so it can be flagged.
    always_comb begin
        next_idx   = '0;
        next_found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(sel_q))) begin
                next_idx   = 3'(i);
                next_found = 1'b1;
            end
        end
    end

    assign dwell_eff = (bus.dwell_in == '0) ? DWELL_W'(1) : bus.dwell_in;
    assign start_idx = lowest_set(bus.mask_in);
    assign first_idx = lowest_set(mask_q);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        en_d    = en_q;
        busy_d  = busy_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        cont_d  = cont_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                sel_d  = '0;
                en_d   = 1'b0;
                busy_d = 1'b0;
                if (bus.start_in) begin
                    if (bus.mask_in != '0) begin
                        mask_d  = bus.mask_in;
                        cont_d  = bus.cont_in;
                        dwell_d = dwell_eff;
                        cnt_d   = dwell_eff - DWELL_W'(1);
                        sel_d   = start_idx;
                        en_d    = 1'b1;
                        busy_d  = 1'b1;
                        state_d = SCAN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (bus.stop_in) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (next_found) begin
                    sel_d = next_idx;
                    cnt_d = dwell_q - DWELL_W'(1);
                end else if (cont_q) begin
                    sel_d  = first_idx;
                    cnt_d  = dwell_q - DWELL_W'(1);
                    wrap_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    sel_d   = '0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            sel_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            mask_q  <= '0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
            cont_q  <= cont_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.sel_out  = sel_q;
    assign bus.en_out   = en_q;
    assign bus.busy_out = busy_q;
    assign bus.wrap_out = wrap_q;
    assign bus.done_out = done_q;
    assign bus.err_out  = err_q;
endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed-vector bench for decoder_scan_ctrl with a behavioural 3x8 decoder on sel_out.
module tb_decoder_scan_ctrl;
    localparam int DWELL_W = 4;

    logic clk_in = 1'b0;
    logic rst_n_in;
    int   n_vec = 0;
    int   n_err = 0;

    decoder_scan_ctrl_if #(.DWELL_W(DWELL_W)) bus ();

    decoder_scan_ctrl #(.DWELL_W(DWELL_W)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    // Decoder inputs: i1 = sel[2], i2 = sel[1], i3 = sel[0]; outputs o1..o8 one-hot.
    logic       dec_i1, dec_i2, dec_i3;
    logic [7:0] dec_o;
    assign dec_i1 = bus.sel_out[2];
    assign dec_i2 = bus.sel_out[1];
    assign dec_i3 = bus.sel_out[0];
    assign dec_o  = 8'b1 << {dec_i1, dec_i2, dec_i3};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_sel"},  32'(bus.sel_out), 0);
        chk({tag, "_en"},   32'(bus.en_out), 0);
        chk({tag, "_busy"}, 32'(bus.busy_out), 0);
        chk({tag, "_wrap"}, 32'(bus.wrap_out), 0);
    endtask

    task automatic start(input logic [7:0] m, input logic [3:0] d, input logic c);
        bus.mask_in  = m;
        bus.dwell_in = d;
        bus.cont_in  = c;
        bus.start_in = 1'b1;
        tick();
        bus.start_in = 1'b0;
    endtask

    task automatic full_pass(input string tag);
        start(8'hFF, 4'd1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s_sel%0d", tag, k), 32'(bus.sel_out), 32'(k));
            chk($sformatf("%s_en%0d", tag, k), 32'(bus.en_out), 1);
            chk($sformatf("%s_dec%0d", tag, k), 32'(dec_o), 32'(8'b1 << k));
            chk($sformatf("%s_done%0d", tag, k), 32'(bus.done_out), 0);
            tick();
        end
        chk_idle({tag, "_end"});
        chk({tag, "_done"}, 32'(bus.done_out), 1);
        tick();
        chk({tag, "_done_clr"}, 32'(bus.done_out), 0);
    endtask

    initial begin
        logic [2:0] exp2 [9];
        logic [2:0] exp3 [10];
        logic       wr3  [10];
        exp2 = '{3'd2, 3'd2, 3'd2, 3'd5, 3'd5, 3'd5, 3'd7, 3'd7, 3'd7};
        exp3 = '{3'd0, 3'd0, 3'd7, 3'd7, 3'd0, 3'd0, 3'd7, 3'd7, 3'd0, 3'd0};
        wr3  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_n_in     = 1'b0;
        bus.start_in = 1'b0;
        bus.stop_in  = 1'b0;
        bus.cont_in  = 1'b0;
        bus.mask_in  = 8'h00;
        bus.dwell_in = '0;
        tick();
        tick();
        chk_idle("rst");
        chk("rst_done", 32'(bus.done_out), 0);
        chk("rst_err",  32'(bus.err_out), 0);
        rst_n_in = 1'b1;

        // 1: full mask, single pass, dwell 1
        full_pass("s1");

        // 2: sparse mask, dwell 3; mask_in changes mid-scan are ignored
        start(8'b1010_0100, 4'd3, 1'b0);
        for (int k = 0; k < 9; k++) begin
            if (k == 1) bus.mask_in = 8'hFF;
            chk($sformatf("s2_sel%0d", k), 32'(bus.sel_out), 32'(exp2[k]));
            chk($sformatf("s2_busy%0d", k), 32'(bus.busy_out), 1);
            tick();
        end
        chk_idle("s2_end");
        chk("s2_done", 32'(bus.done_out), 1);
        tick();

        // 3: continuous wrap, then stop
        start(8'b1000_0001, 4'd2, 1'b1);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("s3_sel%0d", k), 32'(bus.sel_out), 32'(exp3[k]));
            chk($sformatf("s3_wrap%0d", k), 32'(bus.wrap_out), 32'(wr3[k]));
            chk($sformatf("s3_done%0d", k), 32'(bus.done_out), 0);
            if (k == 9) bus.stop_in = 1'b1;
            tick();
        end
        bus.stop_in = 1'b0;
        chk_idle("s3_stop");
        chk("s3_stop_done", 32'(bus.done_out), 0);
        tick();
        chk("s3_idle_busy", 32'(bus.busy_out), 0);

        // 4a: empty mask -> err pulse
        start(8'h00, 4'd1, 1'b0);
        chk("s4_err", 32'(bus.err_out), 1);
        chk("s4_err_busy", 32'(bus.busy_out), 0);
        tick();
        chk("s4_err_clr", 32'(bus.err_out), 0);
        chk("s4_err_busy2", 32'(bus.busy_out), 0);

        // 4b: dwell 0 acts as 1; start during SCAN ignored
        start(8'h03, 4'd0, 1'b0);
        chk("s4_sel0", 32'(bus.sel_out), 0);
        chk("s4_en0", 32'(bus.en_out), 1);
        bus.mask_in  = 8'hF0;
        bus.start_in = 1'b1;
        tick();
        bus.start_in = 1'b0;
        chk("s4_sel1", 32'(bus.sel_out), 1);
        chk("s4_en1", 32'(bus.en_out), 1);
        tick();
        chk_idle("s4_end");
        chk("s4_done", 32'(bus.done_out), 1);
        tick();

        // 5a: reset during the sel=4 dwell
        start(8'hFF, 4'd2, 1'b0);
        for (int k = 0; k < 8; k++) tick();
        chk("s5_pre_sel", 32'(bus.sel_out), 4);
        rst_n_in = 1'b0;
        tick();
        rst_n_in = 1'b1;
        chk_idle("s5_rst");
        chk("s5_rst_done", 32'(bus.done_out), 0);
        full_pass("s5");

        // 5b: stop on the final cycle of the last channel
        start(8'h01, 4'd2, 1'b0);
        chk("s5b_sel0", 32'(bus.sel_out), 0);
        tick();
        chk("s5b_sel1", 32'(bus.sel_out), 0);
        bus.stop_in = 1'b1;
        tick();
        bus.stop_in = 1'b0;
        chk_idle("s5b_stop");
        chk("s5b_done", 32'(bus.done_out), 0);
        tick();
        chk("s5b_done2", 32'(bus.done_out), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
